// File: rtl/note_scheduler.sv
// Falling-note sequencer: per-frame advance, beat-paced pattern fetch and spawn,
// per-lane hit judging and scoring. Per-lane slot logic lives in note_lane.

module note_lane #(
    parameter int SLOTS    = 4,
    parameter int SPEED    = 2,
    parameter int HIT_ROW  = 400,
    parameter int HIT_WIN  = 16,
    parameter int SCREEN_H = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance,
    input  logic                  spawn,
    input  logic                  hit,
    output logic [SLOTS-1:0]      valid,
    output logic [SLOTS-1:0][9:0] y,
    output logic                  hit_now,
    output logic                  miss_now,
    output logic                  drop_now
);
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic [SW-1:0]         cand, free;
    logic                  cand_found, free_found;
    logic [SLOTS-1:0]      valid_hit, valid_next;
    logic [SLOTS-1:0][9:0] y_next;
    logic [10:0]           y_adv;

    // Hit candidate: the lowest note on screen (largest y), lowest index on ties.
    always_comb begin
        cand       = '0;
        cand_found = 1'b0;
        for (int i = 0; i < SLOTS; i++)
            if (valid[i] && (!cand_found || y[i] > y[cand])) begin
                cand       = SW'(i);
                cand_found = 1'b1;
            end
    end

    assign hit_now = hit && cand_found &&
                     (int'(y[cand]) >= HIT_ROW - HIT_WIN) &&
                     (int'(y[cand]) <= HIT_ROW + HIT_WIN);

    // A hit slot drops out before advance/spawn, so it is never advanced or missed.
    always_comb begin
        valid_hit = valid;
        if (hit_now) valid_hit[cand] = 1'b0;
        free       = '0;
        free_found = 1'b0;
        for (int i = SLOTS - 1; i >= 0; i--)
            if (!valid_hit[i]) begin
                free       = SW'(i);
                free_found = 1'b1;
            end
        valid_next = valid_hit;
        y_next     = y;
        miss_now   = 1'b0;
        drop_now   = 1'b0;
        y_adv      = '0;
        for (int i = 0; i < SLOTS; i++) begin
            y_adv = {1'b0, y[i]} + 11'(SPEED);
            if (advance && valid_hit[i]) begin
                if (y_adv >= 11'(SCREEN_H)) begin
                    valid_next[i] = 1'b0;
                    miss_now      = 1'b1;
                end else begin
                    y_next[i] = y_adv[9:0];
                end
            end
        end
        if (spawn) begin
            if (free_found) begin
                valid_next[free] = 1'b1;
                y_next[free]     = '0;
            end else begin
                drop_now = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            y     <= '0;
        end else begin
            valid <= valid_next;
            y     <= y_next;
        end
    end
endmodule

module note_scheduler #(
    parameter int LANES       = 4,
    parameter int SLOTS       = 4,
    parameter int SPEED       = 2,
    parameter int BEAT_FRAMES = 15,
    parameter int PAT_AW      = 6,
    parameter int HIT_ROW     = 400,
    parameter int HIT_WIN     = 16,
    parameter int SCREEN_H    = 480
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        run,
    input  logic                        frame_tick,
    output logic [PAT_AW-1:0]           pat_addr,
    input  logic [LANES-1:0]            pat_data,
    input  logic [LANES-1:0]            hit_req,
    output logic [LANES*SLOTS-1:0]      note_valid,
    output logic [LANES*SLOTS*10-1:0]   note_y,
    output logic [LANES-1:0]            hit_ok,
    output logic [LANES-1:0]            miss,
    output logic [15:0]                 score,
    output logic                        overflow
);
    localparam int BW = (BEAT_FRAMES > 1) ? $clog2(BEAT_FRAMES) : 1;

    typedef enum logic [1:0] {IDLE, ADVANCE, FETCH, SPAWN} state_t;
    state_t state, state_next;

    logic [BW-1:0]                     beat;
    logic                              tick_pend, go, beat_wrap;
    logic [LANES-1:0]                  hit_now, miss_now, drop_now;
    logic [LANES-1:0][SLOTS-1:0]       lane_valid;
    logic [LANES-1:0][SLOTS-1:0][9:0]  lane_y;
    logic [16:0]                       score_sum;

    assign go        = (state == IDLE) && run && (frame_tick || tick_pend);
    assign beat_wrap = (beat == BW'(BEAT_FRAMES - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go) state_next = ADVANCE;
            ADVANCE: state_next = beat_wrap ? FETCH : IDLE;
            FETCH:   state_next = SPAWN;
            SPAWN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        note_lane #(
            .SLOTS(SLOTS), .SPEED(SPEED), .HIT_ROW(HIT_ROW),
            .HIT_WIN(HIT_WIN), .SCREEN_H(SCREEN_H)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .advance  (state == ADVANCE),
            .spawn    ((state == SPAWN) && pat_data[l]),
            .hit      (hit_req[l]),
            .valid    (lane_valid[l]),
            .y        (lane_y[l]),
            .hit_now  (hit_now[l]),
            .miss_now (miss_now[l]),
            .drop_now (drop_now[l])
        );
    end

    // Packed [lane][slot] flattens to index lane*SLOTS+slot.
    assign note_valid = lane_valid;
    assign note_y     = lane_y;

    always_comb begin
        score_sum = {1'b0, score};
        for (int l = 0; l < LANES; l++) score_sum = score_sum + 17'(hit_now[l]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_pend <= 1'b0;
            beat      <= '0;
            pat_addr  <= '0;
            hit_ok    <= '0;
            miss      <= '0;
            score     <= '0;
            overflow  <= 1'b0;
        end else begin
            state  <= state_next;
            hit_ok <= hit_now;
            miss   <= miss_now;
            score  <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
            if (|drop_now) overflow <= 1'b1;
            if (go) tick_pend <= 1'b0;
            else if (frame_tick && run && state != IDLE) tick_pend <= 1'b1;
            if (state == ADVANCE) beat <= beat_wrap ? '0 : beat + BW'(1);
            if (state == SPAWN) pat_addr <= pat_addr + PAT_AW'(1);
        end
    end
endmodule

// File: tb/tb_note_scheduler.sv
// Scoreboarded bench for note_scheduler: a game-level model predicts every cycle's
// outputs; a negedge monitor pops and compares them, plus directed spot checks.

module tb_note_scheduler;
    localparam int LANES = 4, SLOTS = 4, SPEED = 2, BEAT_FRAMES = 15, PAT_AW = 6;
    localparam int HIT_ROW = 400, HIT_WIN = 16, SCREEN_H = 480;
    localparam int P_IDLE = 0, P_ADV = 1, P_FETCH = 2, P_SPAWN = 3;

    logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, frame_tick = 1'b0;
    logic [LANES-1:0] hit_req = '0;
    logic [PAT_AW-1:0] pat_addr;
    logic [LANES-1:0] pat_data;
    logic [LANES*SLOTS-1:0] note_valid;
    logic [LANES*SLOTS*10-1:0] note_y;
    logic [LANES-1:0] hit_ok, miss;
    logic [15:0] score;
    logic overflow;

    note_scheduler dut (
        .clk(clk), .rst_n(rst_n), .run(run), .frame_tick(frame_tick),
        .pat_addr(pat_addr), .pat_data(pat_data), .hit_req(hit_req),
        .note_valid(note_valid), .note_y(note_y), .hit_ok(hit_ok), .miss(miss),
        .score(score), .overflow(overflow)
    );

    always #5 clk = ~clk;

    logic [LANES-1:0] rom [64];
    always @(posedge clk) pat_data <= rom[pat_addr];

    typedef struct {
        logic [LANES*SLOTS-1:0]    nv;
        logic [LANES*SLOTS*10-1:0] ny;
        logic [LANES-1:0]          hit, mis;
        logic [15:0]               score;
        logic                      ovf;
        logic [PAT_AW-1:0]         addr;
    } snap_t;

    snap_t snap_q[$];
    logic [7:0] ev_q[$];
    snap_t ms;
    logic [7:0] mev;
    int checks = 0, failures = 0, miss_seen = 0;

    // Game-level reference state
    int my [LANES][SLOTS];
    bit mv [LANES][SLOTS];
    int m_phase, m_beat, m_addr, m_score;
    bit m_pend, m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < LANES; l++)
            for (int k = 0; k < SLOTS; k++) begin
                my[l][k] = 0;
                mv[l][k] = 0;
            end
        m_phase = P_IDLE; m_beat = 0; m_addr = 0; m_score = 0; m_pend = 0; m_ovf = 0;
    endtask

    task automatic model_step(output logic [LANES-1:0] eh, output logic [LANES-1:0] em);
        int nxt, bi;
        logic [LANES-1:0] pd;
        bit placed;
        eh = '0; em = '0;
        nxt = m_phase;
        for (int l = 0; l < LANES; l++)
            if (hit_req[l]) begin
                bi = -1;
                for (int k = 0; k < SLOTS; k++)
                    if (mv[l][k] && (bi < 0 || my[l][k] > my[l][bi])) bi = k;
                if (bi >= 0 && my[l][bi] >= HIT_ROW - HIT_WIN && my[l][bi] <= HIT_ROW + HIT_WIN) begin
                    mv[l][bi] = 0;
                    eh[l] = 1'b1;
                    if (m_score < 65535) m_score++;
                end
            end
        case (m_phase)
            P_IDLE: if (run && (frame_tick || m_pend)) begin nxt = P_ADV; m_pend = 0; end
            P_ADV: begin
                for (int l = 0; l < LANES; l++)
                    for (int k = 0; k < SLOTS; k++)
                        if (mv[l][k]) begin
                            if (my[l][k] + SPEED >= SCREEN_H) begin mv[l][k] = 0; em[l] = 1'b1; end
                            else my[l][k] = my[l][k] + SPEED;
                        end
                if (m_beat == BEAT_FRAMES - 1) begin m_beat = 0; nxt = P_FETCH; end
                else begin m_beat++; nxt = P_IDLE; end
            end
            P_FETCH: nxt = P_SPAWN;
            default: begin
                pd = rom[m_addr];
                for (int l = 0; l < LANES; l++)
                    if (pd[l]) begin
                        placed = 0;
                        for (int k = 0; k < SLOTS; k++)
                            if (!placed && !mv[l][k]) begin mv[l][k] = 1; my[l][k] = 0; placed = 1; end
                        if (!placed) m_ovf = 1;
                    end
                m_addr = (m_addr + 1) % 64;
                nxt = P_IDLE;
            end
        endcase
        if (m_phase != P_IDLE && run && frame_tick) m_pend = 1;
        m_phase = nxt;
    endtask

    task automatic cycle();
        logic [LANES-1:0] eh, em;
        snap_t sn;
        @(posedge clk);
        model_step(eh, em);
        sn.nv = '0; sn.ny = '0;
        for (int l = 0; l < LANES; l++)
            for (int k = 0; k < SLOTS; k++) begin
                sn.nv[l*SLOTS+k] = mv[l][k];
                sn.ny[(l*SLOTS+k)*10 +: 10] = 10'(my[l][k]);
            end
        sn.hit = eh; sn.mis = em;
        sn.score = 16'(m_score); sn.ovf = m_ovf; sn.addr = PAT_AW'(m_addr);
        snap_q.push_back(sn);
        if ((eh | em) != 0) ev_q.push_back({eh, em});
        #1;
        frame_tick = 1'b0;
        hit_req = '0;
    endtask

    task automatic tick(input bit rnd);
        for (int c = 0; c < 5; c++) begin
            frame_tick = (c == 0);
            if (rnd) hit_req = 4'($urandom) & 4'($urandom) & 4'($urandom);
            cycle();
        end
    endtask

    task automatic ticks(input int n, input bit rnd);
        repeat (n) tick(rnd);
    endtask

    task automatic do_reset();
        if (rst_n) begin
            @(negedge clk); #1;
            chk("pulse_queue_drained", ev_q.size(), 0);
        end
        rst_n = 1'b0; frame_tick = 1'b0; hit_req = '0; run = 1'b1;
        snap_q.delete(); ev_q.delete();
        model_reset();
        miss_seen = 0;
        for (int a = 0; a < 64; a++) rom[a] = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: compares the predicted snapshot each cycle; pulses against the event queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (snap_q.size() > 0) begin
                ms = snap_q.pop_front();
                checks++;
                if (note_valid !== ms.nv || note_y !== ms.ny || hit_ok !== ms.hit || miss !== ms.mis ||
                    score !== ms.score || overflow !== ms.ovf || pat_addr !== ms.addr) begin
                    failures++;
                    $display("FAIL snapshot t=%0t: got nv=%h y=%h hit=%h miss=%h score=%0d ovf=%b addr=%0d exp nv=%h y=%h hit=%h miss=%h score=%0d ovf=%b addr=%0d",
                             $time, note_valid, note_y, hit_ok, miss, score, overflow, pat_addr,
                             ms.nv, ms.ny, ms.hit, ms.mis, ms.score, ms.ovf, ms.addr);
                end
            end
            if ((hit_ok | miss) != 0) begin
                checks++;
                if (miss[0]) miss_seen++;
                if (ev_q.size() == 0) begin
                    failures++;
                    $display("FAIL pulse t=%0t: got hit=%h miss=%h expected no pulse", $time, hit_ok, miss);
                end else begin
                    mev = ev_q.pop_front();
                    if ({hit_ok, miss} !== mev) begin
                        failures++;
                        $display("FAIL pulse t=%0t: got hit=%h miss=%h expected hit=%h miss=%h",
                                 $time, hit_ok, miss, mev[7:4], mev[3:0]);
                    end
                end
            end
        end
    end

    initial begin
        model_reset();
        #12;
        chk("reset_valid", note_valid, 0);
        chk("reset_y", (note_y == 0), 1);
        chk("reset_addr", pat_addr, 0);
        chk("reset_score", score, 0);
        chk("reset_pulses", {hit_ok, miss, overflow}, 0);

        // Spawn, then a hit exactly on the hit line
        do_reset();
        rom[0] = 4'b0001;
        ticks(15, 0);
        chk("spawn_valid", note_valid[0], 1);
        chk("spawn_y", note_y[9:0], 0);
        chk("spawn_addr", pat_addr, 1);
        ticks(200, 0);
        chk("y_at_400", note_y[9:0], 400);
        hit_req = 4'b0001;
        cycle();
        chk("hit_ok", hit_ok, 4'b0001);
        chk("hit_score", score, 1);
        chk("hit_cleared", note_valid[0], 0);

        // Miss at the bottom of the screen
        do_reset();
        rom[0] = 4'b0001;
        ticks(15 + 239, 0);
        chk("y_at_478", note_y[9:0], 478);
        tick(0);
        chk("miss_cleared", note_valid[0], 0);
        chk("miss_score", score, 0);
        chk("miss_pulses", miss_seen, 1);

        // Overflow, then reset during ADVANCE
        do_reset();
        for (int a = 0; a < 5; a++) rom[a] = 4'b0001;
        ticks(75, 0);
        chk("ovf_slots", note_valid[3:0], 4'hF);
        chk("ovf_flag", overflow, 1);
        frame_tick = 1'b1;
        cycle();
        rst_n = 1'b0;
        #1;
        chk("rst_adv_valid", note_valid, 0);
        chk("rst_adv_addr", pat_addr, 0);
        chk("rst_adv_misc", {hit_ok, miss, overflow, score}, 0);

        // Window boundaries and hit during ADVANCE
        do_reset();
        rom[0] = 4'b0011;
        ticks(15 + 191, 0);
        hit_req = 4'b0010;
        cycle();
        chk("no_hit_382", hit_ok, 0);
        chk("no_hit_382_valid", note_valid[4], 1);
        tick(0);
        frame_tick = 1'b1;
        cycle();
        hit_req = 4'b0001;
        cycle();
        chk("hit_on_adv_384", hit_ok, 4'b0001);
        chk("hit_on_adv_not_advanced", note_valid[0], 0);
        chk("other_lane_advanced", note_y[49:40], 386);
        repeat (3) cycle();

        // frame_tick during SPAWN is held pending and serviced afterwards
        do_reset();
        rom[0] = 4'b0001;
        ticks(14, 0);
        frame_tick = 1'b1;
        repeat (3) cycle();
        frame_tick = 1'b1;
        cycle();
        repeat (5) cycle();
        chk("pend_serviced_y", note_y[9:0], 2);

        // Random play through 64 fetches: pattern address wraps
        do_reset();
        for (int a = 0; a < 64; a++) rom[a] = 4'($urandom) & 4'($urandom);
        for (int i = 0; i < 960; i++) begin
            tick(1);
            if (i == 944) chk("addr_63", pat_addr, 63);
            if (i % 40 == 39) begin
                run = 1'b0;
                repeat (6) begin
                    frame_tick = 1'($urandom);
                    hit_req = 4'($urandom) & 4'($urandom);
                    cycle();
                end
                run = 1'b1;
            end
        end
        chk("addr_wrap_0", pat_addr, 0);

        // Free-running random ticks, hits and freezes
        for (int i = 0; i < 3000; i++) begin
            frame_tick = ($urandom_range(0, 5) == 0);
            hit_req = 4'($urandom) & 4'($urandom) & 4'($urandom);
            if (m_phase == P_IDLE && $urandom_range(0, 63) == 0) run = ~run;
            cycle();
        end
        run = 1'b1;
        repeat (4) cycle();
        @(negedge clk); #1;
        chk("final_pulse_queue_drained", ev_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
